// File: rtl/mips_core_pkg.sv
// mips_core_pkg
// Shared core types for the test-status channel between the EX-stage ALU
// and the pass/done monitor.
//   Mtc0Code      : code carried on pass_done_ifc (NOOP/PASS/FAIL/DONE)
//   MonitorStatus : verdict reported by pass_done_monitor
//   MonState      : internal FSM state of pass_done_monitor
//   LogEntry      : one {code, value} record held in the monitor log FIFO
//   sat_inc16     : 16-bit increment that sticks at all-ones
package mips_core_pkg;

    typedef enum logic [1:0] {
        MTC0_NOOP = 2'd0,
        MTC0_PASS = 2'd1,
        MTC0_FAIL = 2'd2,
        MTC0_DONE = 2'd3
    } Mtc0Code;

    typedef enum logic [1:0] {
        MON_RUNNING = 2'd0,
        MON_PASSED  = 2'd1,
        MON_FAILED  = 2'd2,
        MON_TIMEOUT = 2'd3
    } MonitorStatus;

    typedef enum logic [1:0] {
        ST_RUNNING   = 2'd0,
        ST_PASSED    = 2'd1,
        ST_FAILED    = 2'd2,
        ST_TIMED_OUT = 2'd3
    } MonState;

    typedef struct packed {
        Mtc0Code     code;
        logic [15:0] value;
    } LogEntry;

    localparam logic [15:0] TALLY_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == TALLY_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pass_done_ifc.sv
// pass_done_ifc
// Status channel from the EX-stage ALU to the pass/done monitor.
//   code  : Mtc0Code of the instruction currently in EX
//   value : 16-bit payload written by the MTC0
// Modports: source (ALU side), sink (monitor side).
interface pass_done_ifc;
    mips_core_pkg::Mtc0Code code;
    logic [15:0]            value;

    modport source (output code, output value);
    modport sink   (input code, input value);
endinterface

// File: rtl/pass_done_log_fifo.sv
// pass_done_log_fifo
// Small synchronous FIFO holding committed monitor events for a downstream
// reporter. Head is presented with a valid/ready handshake.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : write push_entry this cycle
//   push_entry   : {code, value} to store
//   ready        : consumer accepts the head entry
//   valid        : head entry is valid
//   head         : current head entry (registered storage)
//   overflow     : sticky, set when a push is dropped because the FIFO is full
// LOG_DEPTH must be a power of two and at least 2 so the pointers wrap
// naturally.
module pass_done_log_fifo
    import mips_core_pkg::*;
#(
    parameter int LOG_DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  LogEntry push_entry,
    input  logic    ready,
    output logic    valid,
    output LogEntry head,
    output logic    overflow
);

    localparam int PTR_W = $clog2(LOG_DEPTH);

    LogEntry          mem [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push_ok;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W + 1)'(LOG_DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when the consumer takes the head.
    assign pop     = !empty && ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign valid = !empty;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/pass_done_monitor.sv
// pass_done_monitor
// Receive-side endpoint of pass_done_ifc. Qualifies MTC0 PASS/FAIL/DONE codes
// with the commit strobe, keeps saturating tallies, latches the first failure,
// resolves the test verdict, halts the core and logs every committed event.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   pass_done         : status channel (sink modport)
//   commit            : EX instruction advances this cycle
//   pass_count        : committed PASS events, saturating
//   fail_count        : committed FAIL events, saturating
//   first_fail_valid  : a FAIL has been latched
//   first_fail_value  : value of the first committed FAIL
//   done_value        : value of the committed DONE
//   status            : MonitorStatus verdict
//   halt              : freeze request to the core
//   log_valid/ready   : log FIFO head handshake
//   log_code/value    : log FIFO head entry
//   log_overflow      : sticky, an event was dropped from the log
// Optional feature: define PASS_DONE_WATCHDOG_EN to build the idle watchdog,
// which moves to TIMED_OUT after WATCHDOG_CYCLES event-free RUNNING cycles.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RUNNING   | test in progress, events counted and logged
// ST_PASSED    | DONE seen with no prior failures, core halted
// ST_FAILED    | DONE seen after at least one failure, core halted
// ST_TIMED_OUT | watchdog expired without an event, core halted
module pass_done_monitor
    import mips_core_pkg::*;
#(
    parameter int          LOG_DEPTH       = 8,
    parameter int unsigned WATCHDOG_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    pass_done_ifc.sink    pass_done,
    input  logic          commit,
    output logic [15:0]   pass_count,
    output logic [15:0]   fail_count,
    output logic          first_fail_valid,
    output logic [15:0]   first_fail_value,
    output logic [15:0]   done_value,
    output MonitorStatus  status,
    output logic          halt,
    output logic          log_valid,
    input  logic          log_ready,
    output logic [1:0]    log_code,
    output logic [15:0]   log_value,
    output logic          log_overflow
);

    MonState state_q;
    MonState state_d;
    logic    ev;
    logic    ev_live;
    logic    wd_expire;
    LogEntry log_in;
    LogEntry log_head;

    assign ev      = commit && (pass_done.code != MTC0_NOOP);
    assign ev_live = ev && (state_q == ST_RUNNING);

`ifdef PASS_DONE_WATCHDOG_EN
    logic [31:0] idle_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (state_q == ST_RUNNING) begin
            idle_q <= ev ? 32'd0 : idle_q + 32'd1;
        end
    end

    // An event in the expiry cycle wins: it clears the counter instead.
    assign wd_expire = (state_q == ST_RUNNING) && !ev &&
                       (idle_q == WATCHDOG_CYCLES - 32'd1);
`else
    logic unused_watchdog_cycles;
    assign unused_watchdog_cycles = ^WATCHDOG_CYCLES;
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUNNING;
        end else begin
            state_q <= state_d;
        end
    end

    // The verdict uses fail_count as registered: only failures committed in
    // earlier cycles can decide it.
    always_comb begin
        state_d = state_q;
        if (ev_live && (pass_done.code == MTC0_DONE)) begin
            state_d = (fail_count == 16'd0) ? ST_PASSED : ST_FAILED;
        end else if (wd_expire) begin
            state_d = ST_TIMED_OUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_value <= '0;
            done_value       <= '0;
        end else if (ev_live) begin
            case (pass_done.code)
                MTC0_PASS: pass_count <= sat_inc16(pass_count);
                MTC0_FAIL: begin
                    fail_count <= sat_inc16(fail_count);
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_value <= pass_done.value;
                    end
                end
                MTC0_DONE: done_value <= pass_done.value;
                default: ;
            endcase
        end
    end

    always_comb begin
        status = MON_RUNNING;
        case (state_q)
            ST_RUNNING:   status = MON_RUNNING;
            ST_PASSED:    status = MON_PASSED;
            ST_FAILED:    status = MON_FAILED;
            ST_TIMED_OUT: status = MON_TIMEOUT;
            default:      status = MON_RUNNING;
        endcase
    end

    assign halt = (state_q != ST_RUNNING);

    assign log_in.code  = pass_done.code;
    assign log_in.value = pass_done.value;

    pass_done_log_fifo #(
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ev_live),
        .push_entry (log_in),
        .ready      (log_ready),
        .valid      (log_valid),
        .head       (log_head),
        .overflow   (log_overflow)
    );

    assign log_code  = log_head.code;
    assign log_value = log_head.value;

endmodule
